// File: rtl/amp3_i2s_tx.sv
// I2S / left-justified stereo transmitter for the Pmod AMP3. BCLK and LRCLK are
// divided down from clk; samples enter through a one-frame holding register.
module amp3_i2s_tx #(
  parameter int DATASIZE = 16,
  parameter int SLOTSIZE = 32,
  parameter int CLKDIV   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       mode_lj,
  input  logic signed [DATASIZE-1:0] data_l,
  input  logic signed [DATASIZE-1:0] data_r,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       BCLK,
  output logic                       LRCLK,
  output logic                       SDATA,
  output logic                       nSHUT,
  output logic                       right_n_left,
  output logic                       underrun
);
  localparam int DIV_W = $clog2(CLKDIV);
  localparam int K_W   = $clog2(2 * SLOTSIZE);

  logic [DIV_W-1:0] div_q, div_d;
  logic [K_W-1:0]   k_q, k_d;
  logic bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d, rnl_q, rnl_d;
  logic mode_q, mode_d, nshut_q, nshut_d, underrun_q, underrun_d, ready_q, ready_d;
  logic signed [DATASIZE-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic signed [DATASIZE-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic signed [DATASIZE-1:0] new_l, new_r;
  logic xfer, div_tc, fall, mode_use;

  // Left-justified bit for falling edge k of a frame carrying words wl/wr.
  function automatic logic lj_bit(input logic [K_W-1:0] k,
                                  input logic signed [DATASIZE-1:0] wl,
                                  input logic signed [DATASIZE-1:0] wr);
    logic [K_W-1:0]      b;
    logic [DATASIZE-1:0] sh;
    b  = (k >= K_W'(SLOTSIZE)) ? k - K_W'(SLOTSIZE) : k;
    sh = (k >= K_W'(SLOTSIZE)) ? wr : wl;
    sh = sh << b;
    return (b < K_W'(DATASIZE)) ? sh[DATASIZE-1] : 1'b0;
  endfunction

  always_comb begin
    div_d      = div_q;
    k_d        = k_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    rnl_d      = rnl_q;
    mode_d     = mode_q;
    nshut_d    = enable;
    underrun_d = 1'b0;
    ready_d    = ready_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    frame_l_d  = frame_l_q;
    frame_r_d  = frame_r_q;
    new_l      = frame_l_q;
    new_r      = frame_r_q;
    mode_use   = mode_q;
    div_tc     = 1'b0;
    fall       = 1'b0;
    xfer       = sample_valid && ready_q;

    if (xfer) begin
      hold_l_d = data_l;
      hold_r_d = data_r;
      ready_d  = 1'b0;
    end

    if (!enable) begin
      div_d     = '0;
      k_d       = '0;
      bclk_d    = 1'b0;
      lrclk_d   = 1'b0;
      sdata_d   = 1'b0;
      rnl_d     = 1'b0;
      frame_l_d = '0;
      frame_r_d = '0;
    end else begin
      div_tc = (div_q == DIV_W'(CLKDIV - 1));
      div_d  = div_tc ? '0 : div_q + 1'b1;
      if (div_tc) bclk_d = ~bclk_q;
      fall = div_tc && bclk_q;

      if (fall) begin
        if (k_q == '0) begin
          mode_use = mode_lj;
          mode_d   = mode_lj;
          if (!ready_q) begin
            new_l   = hold_l_q;
            new_r   = hold_r_q;
            ready_d = 1'b1;
          end else if (xfer) begin
            // Bypass: the arriving sample goes straight into the frame.
            new_l   = data_l;
            new_r   = data_r;
            ready_d = 1'b1;
          end else begin
            new_l      = '0;
            new_r      = '0;
            underrun_d = 1'b1;
          end
          frame_l_d = new_l;
          frame_r_d = new_r;
        end

        k_d     = (k_q == K_W'(2 * SLOTSIZE - 1)) ? '0 : k_q + 1'b1;
        lrclk_d = (k_q >= K_W'(SLOTSIZE));
        if (mode_use) begin
          sdata_d = lj_bit(k_q, new_l, new_r);
          rnl_d   = lrclk_d;
        end else begin
          // I2S lags by one edge; edge 0 still carries the old frame's last bit.
          sdata_d = (k_q == '0) ? lj_bit(K_W'(2 * SLOTSIZE - 1), frame_l_q, frame_r_q)
                                : lj_bit(k_q - 1'b1, new_l, new_r);
          rnl_d   = lrclk_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      k_q        <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      rnl_q      <= 1'b0;
      mode_q     <= 1'b0;
      nshut_q    <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b1;
      frame_l_q  <= '0;
      frame_r_q  <= '0;
    end else begin
      div_q      <= div_d;
      k_q        <= k_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      rnl_q      <= rnl_d;
      mode_q     <= mode_d;
      nshut_q    <= nshut_d;
      underrun_q <= underrun_d;
      ready_q    <= ready_d;
      frame_l_q  <= frame_l_d;
      frame_r_q  <= frame_r_d;
    end
  end

  // Holding data is only meaningful while ready_q is low.
  always_ff @(posedge clk) begin
    hold_l_q <= hold_l_d;
    hold_r_q <= hold_r_d;
  end

  assign sample_ready = ready_q;
  assign BCLK         = bclk_q;
  assign LRCLK        = lrclk_q;
  assign SDATA        = sdata_q;
  assign nSHUT        = nshut_q;
  assign right_n_left = rnl_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_amp3_i2s_tx.sv
// Bench for amp3_i2s_tx at default parameters: a cycle-count reference model with
// a sample scoreboard, a vector table of frames, and hand-written corner sequences.
module tb_amp3_i2s_tx;
  logic        clk = 1'b0;
  logic        rst, enable, mode_lj, sample_valid;
  logic [15:0] data_l, data_r;
  logic        sample_ready, BCLK, LRCLK, SDATA, nSHUT, right_n_left, underrun;

  amp3_i2s_tx #(.DATASIZE(16), .SLOTSIZE(32), .CLKDIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode_lj(mode_lj),
    .data_l(data_l), .data_r(data_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA),
    .nSHUT(nSHUT), .right_n_left(right_n_left), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // Reference model state
  logic [15:0] pend_l[$], pend_r[$];
  logic [63:0] lj_s, tmp_s;
  logic        lj_last, m_mode, xfer_m;
  logic        e_bclk, e_lrclk, e_sdata, e_rnl, e_ur, e_ready, e_nshut;
  int          t_en, kk, m_k;
  logic [15:0] nl, nr;

  // Frame stream: bit for edge k sits at position 63-k.
  function automatic logic [63:0] mk_stream(input logic [15:0] l, input logic [15:0] r);
    return {l, 16'h0000, r, 16'h0000};
  endfunction

  initial begin
    lj_s = '0; lj_last = 1'b0; m_mode = 1'b0; t_en = 0; m_k = -1;
    e_bclk = 0; e_lrclk = 0; e_sdata = 0; e_rnl = 0; e_ur = 0; e_ready = 1; e_nshut = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        pend_l.delete(); pend_r.delete();
        lj_s = '0; lj_last = 1'b0; m_mode = 1'b0; t_en = 0; m_k = -1;
        e_bclk = 0; e_lrclk = 0; e_sdata = 0; e_rnl = 0; e_ur = 0; e_ready = 1; e_nshut = 0;
      end else begin
        e_nshut = enable;
        e_ur    = 1'b0;
        xfer_m  = sample_valid && (pend_l.size() == 0);
        if (xfer_m) begin pend_l.push_back(data_l); pend_r.push_back(data_r); end
        if (!enable) begin
          t_en = 0; m_k = -1; lj_s = '0; lj_last = 1'b0;
          e_bclk = 0; e_lrclk = 0; e_sdata = 0; e_rnl = 0;
        end else begin
          t_en++;
          e_bclk = ((t_en / 4) % 2) == 1;
          if (t_en % 8 == 0) begin
            kk = (t_en / 8 - 1) % 64;
            m_k = kk;
            if (kk == 0) begin
              lj_last = lj_s[0];
              m_mode  = mode_lj;
              if (pend_l.size() > 0) begin nl = pend_l.pop_front(); nr = pend_r.pop_front(); end
              else begin nl = 16'h0; nr = 16'h0; e_ur = 1'b1; end
              lj_s = mk_stream(nl, nr);
            end
            e_rnl   = m_mode ? (kk >= 32) : e_lrclk;
            e_lrclk = (kk >= 32);
            if (m_mode) tmp_s = lj_s << kk;
            else if (kk == 0) tmp_s = {lj_last, 63'h0};
            else tmp_s = lj_s << (kk - 1);
            e_sdata = tmp_s[63];
          end
        end
        e_ready = (pend_l.size() == 0);
      end
    end
  end

  // Per-cycle comparison and amplifier-side capture on BCLK rising edges
  logic [63:0] cap = '0;
  logic        prev_bclk = 1'b0;
  logic [15:0] got_l[$], got_r[$];
  int          ur_seen = 0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("bclk", BCLK, e_bclk);
      chk("lrclk", LRCLK, e_lrclk);
      chk("sdata", SDATA, e_sdata);
      chk("rnl", right_n_left, e_rnl);
      chk("underrun", underrun, e_ur);
      chk("ready", sample_ready, e_ready);
      chk("nshut", nSHUT, e_nshut);
      if (underrun) ur_seen++;
      if (BCLK && !prev_bclk && m_k >= 0) begin
        if (m_k == 0) cap = '0;
        cap = cap | (64'(SDATA) << (63 - m_k));
        if (m_k == 63) begin
          if (m_mode) begin got_l.push_back(cap[63:48]); got_r.push_back(cap[31:16]); end
          else begin got_l.push_back(cap[62:47]); got_r.push_back(cap[30:15]); end
        end
      end
    end
    prev_bclk = BCLK;
  end

  task automatic send(input logic [15:0] l, input logic [15:0] r, output int waited);
    bit acc;
    acc = 1'b0; waited = 0;
    data_l = l; data_r = r; sample_valid = 1'b1;
    while (!acc && waited < 2000) begin
      acc = sample_ready;
      @(negedge clk);
      waited++;
    end
    sample_valid = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic wait_frame(input int need, input int budget);
    int n;
    n = 0;
    while (got_l.size() < need && n < budget) begin @(negedge clk); n++; end
    chk("frame_timeout", got_l.size() >= need, 1);
  endtask

  task automatic wait_k(input int target);
    int n;
    n = 0;
    while (m_k != target && n < 700) begin @(negedge clk); n++; end
    chk("k_timeout", m_k == target, 1);
  endtask

  typedef struct {
    logic        mode;
    logic [15:0] dl, dr, exp_l, exp_r;
  } vec_t;
  vec_t tbl[4];

  int w;

  initial begin
    tbl[0] = '{1'b1, 16'hA5C3, 16'h0F0F, 16'hA5C3, 16'h0F0F};
    tbl[1] = '{1'b0, 16'hA5C3, 16'h0F0F, 16'hA5C3, 16'h0F0F};
    tbl[2] = '{1'b1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
    tbl[3] = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};

    rst = 1'b1; enable = 1'b0; mode_lj = 1'b1; sample_valid = 1'b0;
    data_l = '0; data_r = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_bclk", BCLK, 0);
    chk("rst_sdata", SDATA, 0);
    chk("rst_nshut", nSHUT, 0);
    chk("rst_ready", sample_ready, 1);

    // Frame vectors: sample held while disabled, transmitted in the first frame
    for (int i = 0; i < 4; i++) begin
      enable = 1'b0;
      repeat (2) @(negedge clk);
      got_l.delete(); got_r.delete();
      mode_lj = tbl[i].mode;
      send(tbl[i].dl, tbl[i].dr, w);
      enable = 1'b1;
      wait_frame(1, 700);
      enable = 1'b0;
      if (got_l.size() > 0) begin
        chk($sformatf("vec%0d_left", i), got_l[0], tbl[i].exp_l);
        chk($sformatf("vec%0d_right", i), got_r[0], tbl[i].exp_r);
      end
    end

    // Underrun: no samples, mode changed mid-frame
    repeat (2) @(negedge clk);
    mode_lj = 1'b0; ur_seen = 0; enable = 1'b1;
    repeat (300) @(negedge clk);
    mode_lj = 1'b1;
    repeat (724) @(negedge clk);
    chk("underrun_pulses", ur_seen, 2);

    // Backpressure: A bypasses at k=0, B held, C waits a full frame
    enable = 1'b0;
    repeat (2) @(negedge clk);
    got_l.delete(); got_r.delete();
    enable = 1'b1;
    repeat (7) @(negedge clk);
    send(16'h1111, 16'h2222, w); chk("bp_wait_a", w, 1);
    send(16'h3333, 16'h4444, w); chk("bp_wait_b", w, 1);
    send(16'h5555, 16'h6666, w); chk("bp_wait_c", w, 512);
    wait_frame(3, 2000);
    if (got_l.size() >= 3) begin
      chk("bp_a", {got_l[0], got_r[0]}, 32'h11112222);
      chk("bp_b", {got_l[1], got_r[1]}, 32'h33334444);
      chk("bp_c", {got_l[2], got_r[2]}, 32'h55556666);
    end

    // Enable drop at k=20 with a sample still held
    enable = 1'b0;
    repeat (2) @(negedge clk);
    got_l.delete(); got_r.delete();
    send(16'hC0DE, 16'hBEEF, w);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    send(16'h1234, 16'h5678, w);
    wait_k(20);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_bclk", BCLK, 0);
    chk("drop_lrclk", LRCLK, 0);
    chk("drop_sdata", SDATA, 0);
    chk("drop_ready", sample_ready, 0);
    repeat (10) @(negedge clk);
    chk("drop_nocap", got_l.size(), 0);
    enable = 1'b1;
    wait_frame(1, 700);
    if (got_l.size() > 0) chk("drop_resume", {got_l[0], got_r[0]}, 32'h12345678);

    // Asynchronous reset during transmission
    enable = 1'b0; mode_lj = 1'b0;
    repeat (2) @(negedge clk);
    send(16'hFFFF, 16'hFFFF, w);
    enable = 1'b1;
    wait_k(5);
    #1 rst = 1'b1;
    #1;
    chk("arst_bclk", BCLK, 0);
    chk("arst_lrclk", LRCLK, 0);
    chk("arst_sdata", SDATA, 0);
    chk("arst_nshut", nSHUT, 0);
    chk("arst_ready", sample_ready, 1);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_ready", sample_ready, 1);
    chk("post_rst_lrclk", LRCLK, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
